// File: rtl/core_test_monitor_if.sv
// -----------------------------------------------------------------------------
// core_test_monitor_if
// Core-side probe bus that the test monitor observes.
//   PC          : core program counter
//   instruction : ROM output at PC
//   MemWrite    : core store strobe
//   alu_result  : store address
//   read_data2  : store data
// Modports: master = the core (drives the probes), slave = the monitor.
// -----------------------------------------------------------------------------
interface core_test_monitor_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] PC;
  logic [31:0]       instruction;
  logic              MemWrite;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] read_data2;

  modport master (output PC, instruction, MemWrite, alu_result, read_data2);
  modport slave  (input  PC, instruction, MemWrite, alu_result, read_data2);
endinterface

// File: rtl/core_test_monitor.sv
// -----------------------------------------------------------------------------
// core_test_monitor
// Watches a CPU core running a self-test program and decides when and how the
// test ended: by a halt loop (jal x0,0 or ebreak repeated at a fixed PC), by a
// store to the tohost mailbox, or by a cycle timeout.
//
// Ports
//   CLK, RESET_N  : clock (rising edge) and asynchronous active-low reset
//   enable        : starts the monitor from IDLE and gates counting in RUN
//   core          : core probe bus (core_test_monitor_if.slave)
//   done          : test has ended (sticky until reset)
//   pass          : test passed, valid while done is high
//   timeout       : test ended because the cycle budget ran out
//   fail_code     : tohost failure code (store data >> 1)
//   cycle_count   : RUN cycles with enable high (saturating)
//   instr_count   : PC changes seen in RUN with enable high (saturating)
//   state         : FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature: define CORE_TEST_MONITOR_TOHOST_EN to enable the tohost
// mailbox. Without it fail_code is tied to zero and only halt/timeout end
// the test.
// -----------------------------------------------------------------------------
module core_test_monitor #(
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 32,
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 10'h3FC,
  parameter int                TIMEOUT     = 100000,
  parameter int                HALT_REPEAT = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 enable,
  core_test_monitor_if.slave   core,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [DATA_W-1:0]    fail_code,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     instr_count,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0]      INSTR_JAL_SELF = 32'h0000_006F;  // jal x0,0
  localparam logic [31:0]      INSTR_EBREAK   = 32'h0010_0073;
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]       HALT_TARGET    = 5'(HALT_REPEAT);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] prev_pc;
  logic [3:0]        halt_cnt;

  logic run;
  logic run_en;
  logic halt_cond;
  logic halt_fire;
  logic timeout_fire;
  logic tohost_fire;
  logic tohost_pass;
  logic end_evt;

  assign state  = state_q;
  assign run    = (state_q == ST_RUN);
  assign run_en = run && enable;

  // Halt: the core sits on a self-loop or ebreak without moving its PC.
  assign halt_cond = ((core.instruction == INSTR_JAL_SELF) ||
                      (core.instruction == INSTR_EBREAK)) &&
                     (core.PC == prev_pc);

  // Fire on the cycle whose sample makes the run HALT_REPEAT long, so DONE is
  // entered on that same edge rather than one cycle after the counter fills.
  assign halt_fire = run_en && halt_cond &&
                     (({1'b0, halt_cnt} + 5'd1) >= HALT_TARGET);

  // Timeout is judged on the registered count, which is frozen on the ending
  // edge, so cycle_count reads TIMEOUT-1 once the test has timed out.
  assign timeout_fire = run_en && (cycle_count == TIMEOUT_LAST);

`ifdef CORE_TEST_MONITOR_TOHOST_EN
  // A store of zero to the mailbox is not an end event.
  assign tohost_fire = run && core.MemWrite &&
                       (core.alu_result[ADDR_W-1:0] == TOHOST_ADDR) &&
                       (core.read_data2 != '0);
  assign tohost_pass = (core.read_data2 == DATA_W'(1));
`else
  assign tohost_fire = 1'b0;
  assign tohost_pass = 1'b0;
  assign fail_code   = '0;

  logic unused_store_bus;
  assign unused_store_bus = core.MemWrite ^ (^core.alu_result) ^ (^core.read_data2);
`endif

  assign end_evt = tohost_fire || halt_fire || timeout_fire;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d is given its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (end_evt) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;  // 2'd3 is never entered legitimately
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and previous-PC tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_pc     <= '0;
      halt_cnt    <= '0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      prev_pc <= core.PC;

      // Only consecutive enabled RUN cycles build up a halt run.
      if (run_en && halt_cond) begin
        if (halt_cnt != 4'hF) halt_cnt <= halt_cnt + 4'd1;
      end else begin
        halt_cnt <= '0;
      end

      if (run_en && !end_evt) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CNT_ONE;
        if ((core.PC != prev_pc) && (instr_count != '1))
          instr_count <= instr_count + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: written once, on the edge that enters DONE.
  // Priority: tohost, then halt, then timeout.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
`ifdef CORE_TEST_MONITOR_TOHOST_EN
      fail_code <= '0;
`endif
    end else if (run && end_evt) begin
      done <= 1'b1;
      if (tohost_fire) begin
        pass    <= tohost_pass;
        timeout <= 1'b0;
`ifdef CORE_TEST_MONITOR_TOHOST_EN
        fail_code <= core.read_data2 >> 1;
`endif
      end else if (halt_fire) begin
        pass    <= 1'b1;
        timeout <= 1'b0;
      end else begin
        pass    <= 1'b0;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_core_test_monitor
// Directed self-checking bench for core_test_monitor (TIMEOUT reduced to 50,
// other parameters at their defaults). Inputs change 1 ns after each rising
// edge and outputs are checked there too, so every check sees the state the
// edge just produced. Tohost checks follow CORE_TEST_MONITOR_TOHOST_EN.
// -----------------------------------------------------------------------------
module tb_core_test_monitor;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JAL    = 32'h0000_006F;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] TOHOST = 32'h0000_03FC;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              enable;
  logic              done, pass, timeout;
  logic [DATA_W-1:0] fail_code;
  logic [CNT_W-1:0]  cycle_count, instr_count;
  logic [1:0]        state;

  int n_checks = 0;
  int n_errors = 0;

  core_test_monitor_if #(.DATA_W(DATA_W)) core_bus ();

  core_test_monitor #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(50)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .enable     (enable),
    .core       (core_bus),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .fail_code  (fail_code),
    .cycle_count(cycle_count),
    .instr_count(instr_count),
    .state      (state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of core activity, then look just after the edge.
  task automatic cyc(input logic en, input logic [31:0] pc, input logic [31:0] instr,
                     input logic mw = 1'b0, input logic [31:0] addr = '0,
                     input logic [31:0] data = '0);
    enable               = en;
    core_bus.PC          = pc;
    core_bus.instruction = instr;
    core_bus.MemWrite    = mw;
    core_bus.alu_result  = addr;
    core_bus.read_data2  = data;
    @(posedge CLK);
    #1;
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    enable            = 1'b0;
    core_bus.MemWrite = 1'b0;
    core_bus.PC       = '0;
    RESET_N           = 1'b0;
    #1;
    check({tag, "_state"}, state, 2'd0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_fail_code"}, fail_code, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_instr_count"}, instr_count, 0);
    #5;
    RESET_N = 1'b1;
  endtask

  initial begin
    int pc;
    int n_en;

    enable               = 1'b0;
    core_bus.PC          = '0;
    core_bus.instruction = NOP;
    core_bus.MemWrite    = 1'b0;
    core_bus.alu_result  = '0;
    core_bus.read_data2  = '0;

    // ---- Power-on reset, then IDLE must wait for enable ----
    do_reset("por");
    cyc(1'b0, 32'h10, NOP);
    check("idle_hold_state", state, 2'd0);

    // ---- Straight-line code then jal x0,0 halt ----
    do_reset("halt_rst");
    cyc(1'b1, 0, NOP);
    check("enter_run_state", state, 2'd1);
    check("enter_run_no_count", cycle_count, 0);
    for (int i = 1; i <= 10; i++) cyc(1'b1, 4 * i, NOP);
    check("run_cycle_count", cycle_count, 10);
    check("run_instr_count", instr_count, 10);
    cyc(1'b1, 40, JAL);
    check("halt_first_not_done", done, 1'b0);
    cyc(1'b1, 40, JAL);
    check("halt_done", done, 1'b1);
    check("halt_pass", pass, 1'b1);
    check("halt_timeout", timeout, 1'b0);
    check("halt_instr_count", instr_count, 10);
    check("halt_state", state, 2'd2);
    // DONE is sticky and ignores inputs.
    cyc(1'b1, 100, NOP);
    cyc(1'b0, 200, NOP);
    check("done_sticky", done, 1'b1);
    check("done_sticky_pass", pass, 1'b1);
    check("done_frozen_instr", instr_count, 10);
    check("done_sticky_state", state, 2'd2);

    // ---- Interrupted ebreak run ----
    do_reset("ebrk_rst");
    cyc(1'b1, 0, NOP);
    cyc(1'b1, 4, NOP);
    cyc(1'b1, 4, EBRK);
    cyc(1'b1, 4, NOP);
    check("ebrk_broken_run", done, 1'b0);
    cyc(1'b1, 4, EBRK);
    check("ebrk_second_first", done, 1'b0);
    cyc(1'b1, 4, EBRK);
    check("ebrk_done", done, 1'b1);
    check("ebrk_pass", pass, 1'b1);
    check("ebrk_instr_count", instr_count, 1);

    // ---- Timeout, with an enable=0 pause that freezes everything ----
    do_reset("to_rst");
    cyc(1'b1, 0, NOP);
    pc   = 0;
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      pc += 4;
      cyc(1'b1, pc, NOP);
      n_en++;
    end
    check("pause_pre_count", cycle_count, 5);
    for (int i = 0; i < 3; i++) begin
      pc += 4;
      cyc(1'b0, pc, NOP);
    end
    check("pause_cycle_frozen", cycle_count, 5);
    check("pause_instr_frozen", instr_count, 5);
    check("pause_state_run", state, 2'd1);
    while (!done && n_en < 200) begin
      pc += 4;
      cyc(1'b1, pc, NOP);
      n_en++;
    end
    check("to_done", done, 1'b1);
    check("to_enabled_cycles", n_en, 50);
    check("to_timeout", timeout, 1'b1);
    check("to_pass", pass, 1'b0);
    check("to_cycle_count", cycle_count, 49);
    check("to_state", state, 2'd2);

    // ---- Asynchronous reset mid-RUN ----
    do_reset("mid_pre_rst");
    cyc(1'b1, 0, NOP);
    cyc(1'b1, 4, NOP);
    cyc(1'b1, 8, NOP);
    check("mid_counting", cycle_count, 2);
    #3;
    do_reset("mid_rst");
    cyc(1'b0, 12, NOP);
    cyc(1'b0, 16, NOP);
    check("mid_after_state", state, 2'd0);
    check("mid_after_cycles", cycle_count, 0);
    check("mid_after_instr", instr_count, 0);
    cyc(1'b1, 20, NOP);
    check("mid_restart_state", state, 2'd1);
    check("mid_restart_no_count", cycle_count, 0);

`ifdef CORE_TEST_MONITOR_TOHOST_EN
    // ---- Tohost mailbox ----
    do_reset("th_rst");
    cyc(1'b1, 0, NOP);
    cyc(1'b1, 4, NOP, 1'b1, TOHOST, 32'h0);
    check("th_zero_ignored", done, 1'b0);
    cyc(1'b1, 8, NOP, 1'b1, 32'h3F8, 32'h7);
    check("th_wrong_addr", done, 1'b0);
    cyc(1'b1, 12, NOP, 1'b0, TOHOST, 32'h7);
    check("th_no_memwrite", done, 1'b0);
    cyc(1'b1, 16, NOP, 1'b1, 32'h0001_03FC, 32'h7);
    check("th_fail_done", done, 1'b1);
    check("th_fail_pass", pass, 1'b0);
    check("th_fail_code", fail_code, 3);
    check("th_fail_timeout", timeout, 1'b0);

    // Tohost beats a halt completing in the same cycle.
    do_reset("thh1_rst");
    cyc(1'b1, 0, NOP);
    cyc(1'b1, 0, JAL);
    cyc(1'b1, 0, JAL, 1'b1, TOHOST, 32'h1);
    check("thh1_done", done, 1'b1);
    check("thh1_pass", pass, 1'b1);
    check("thh1_code", fail_code, 0);

    do_reset("thh3_rst");
    cyc(1'b1, 0, NOP);
    cyc(1'b1, 0, JAL);
    cyc(1'b1, 0, JAL, 1'b1, TOHOST, 32'h3);
    check("thh3_done", done, 1'b1);
    check("thh3_pass", pass, 1'b0);
    check("thh3_code", fail_code, 1);
`else
    // ---- Without the mailbox a tohost store changes nothing ----
    do_reset("nth_rst");
    cyc(1'b1, 0, NOP);
    cyc(1'b1, 0, JAL, 1'b1, TOHOST, 32'h7);
    check("nth_not_done", done, 1'b0);
    check("nth_code_zero", fail_code, 0);
    cyc(1'b1, 0, JAL, 1'b1, TOHOST, 32'h3);
    check("nth_halt_done", done, 1'b1);
    check("nth_halt_pass", pass, 1'b1);
    check("nth_halt_code", fail_code, 0);
`endif

    do_reset("final_rst");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
